gpio_input_conditioner: RTL and testbench

Upstream stage for the multicycle MIPS core's 8-bit GPIO_i input. It takes asynchronous board pins (switches/buttons), synchronizes them to clk, and debounces each bit independently. It presents a stable word to the core, with per-bit edge pulses and a sticky "input changed" flag that firmware-side logic acknowledges. Pure clk domain; no combinational path from pins_i to any output.

---
 rtl/gpio_input_conditioner.sv | 67 ++++++
 tb/tb_gpio_input_conditioner.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_input_conditioner.sv
// Synchronizes and debounces asynchronous GPIO pins, presenting a stable word
// with per-bit edge pulses and a sticky change flag cleared by ack_i.
module gpio_input_conditioner #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins_i,
  input  logic             ack_i,
  output logic [WIDTH-1:0] GPIO_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             event_o
);

  localparam int unsigned CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]     sync1;
  logic [WIDTH-1:0]     sync2;
  logic [WIDTH-1:0]     upd;
  logic [CNT_WIDTH-1:0] cnt     [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_nxt [WIDTH];

  // A bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples;
  // any agreeing sample restarts its count.
  always_comb begin
    upd = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != GPIO_o[i]) begin
        if (cnt[i] >= CNT_MAX) begin
          upd[i] = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= '0;
      sync2   <= '0;
      GPIO_o  <= '0;
      rise_o  <= '0;
      fall_o  <= '0;
      event_o <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1   <= pins_i;
      sync2   <= sync1;
      GPIO_o  <= GPIO_o ^ upd;
      rise_o  <= upd & ~GPIO_o;
      fall_o  <= upd & GPIO_o;
      // A new change wins over a simultaneous acknowledge.
      event_o <= (|upd) | (event_o & ~ack_i);
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Scoreboard bench: two conditioners (debounce 4 and 1) share stimulus and are
// compared each cycle against a sliding-window reference model.
module tb_gpio_input_conditioner;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] gpio;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         ev;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         ack;
  logic [W-1:0] pins;
  logic [W-1:0] g0, r0, f0, g1, r1, f1;
  logic         e0, e1;

  int vectors     = 0;
  int miscompares = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model state: synchronizer image plus a history window of
  // synchronized samples since reset, newest at index 0.
  logic [W-1:0] m_s1   [2];
  logic [W-1:0] m_s2   [2];
  logic [W-1:0] m_out  [2];
  logic         m_ev   [2];
  logic [W-1:0] hist   [2][8];
  int           nsince [2];

  gpio_input_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) dut0 (
    .clk(clk), .rst(rst), .pins_i(pins), .ack_i(ack),
    .GPIO_o(g0), .rise_o(r0), .fall_o(f0), .event_o(e0)
  );

  gpio_input_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .pins_i(pins), .ack_i(ack),
    .GPIO_o(g1), .rise_o(r1), .fall_o(f1), .event_o(e1)
  );

  always #5 clk = ~clk;

  function automatic int n_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_s1[d]   = '0;
      m_s2[d]   = '0;
      m_out[d]  = '0;
      m_ev[d]   = 1'b0;
      nsince[d] = 0;
      for (int j = 0; j < 8; j++) hist[d][j] = '0;
    end
  endtask

  // One clock edge: a bit flips when the last N synchronized samples all
  // disagree with the current stable value.
  task automatic model_step(input int d, input logic [W-1:0] p, input logic a,
                            output exp_t e);
    logic [W-1:0] u;
    int n;
    n = n_of(d);
    for (int j = 7; j > 0; j--) hist[d][j] = hist[d][j-1];
    hist[d][0] = m_s2[d];
    if (nsince[d] < 8) nsince[d] = nsince[d] + 1;
    u = '0;
    if (nsince[d] >= n) begin
      for (int i = 0; i < W; i++) begin
        logic all_diff;
        all_diff = 1'b1;
        for (int j = 0; j < n; j++)
          if (hist[d][j][i] == m_out[d][i]) all_diff = 1'b0;
        u[i] = all_diff;
      end
    end
    e.rise   = u & ~m_out[d];
    e.fall   = u & m_out[d];
    m_out[d] = m_out[d] ^ u;
    m_ev[d]  = (|u) | (m_ev[d] & ~a);
    e.gpio   = m_out[d];
    e.ev     = m_ev[d];
    m_s2[d]  = m_s1[d];
    m_s1[d]  = p;
  endtask

  task automatic dchk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Entered at a negedge; drives inputs for the next rising edge and returns
  // at the following negedge, after that edge has been taken.
  task automatic cycle(input logic [W-1:0] p, input logic a);
    exp_t e;
    pins = p;
    ack  = a;
    model_step(0, p, a, e);
    q0.push_back(e);
    model_step(1, p, a, e);
    q1.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    dchk("rst_async_dut0", 32'({g0, r0, f0, e0}), 32'd0);
    dchk("rst_async_dut1", 32'({g1, r1, f1, e1}), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [W-1:0] rp;
    rst  = 1'b0;
    ack  = 1'b0;
    pins = '0;
    model_reset();
    fork
      begin : monitor
        forever begin
          exp_t e;
          exp_t a;
          @(posedge clk);
          #1;
          if (q0.size() > 0) begin
            e = q0.pop_front();
            a = '{g0, r0, f0, e0};
            vectors++;
            if (a !== e) begin
              miscompares++;
              $display("FAIL sb_dut0 t=%0t: gpio/rise/fall/ev got %h/%h/%h/%b want %h/%h/%h/%b",
                       $time, a.gpio, a.rise, a.fall, a.ev, e.gpio, e.rise, e.fall, e.ev);
            end
          end
          if (q1.size() > 0) begin
            e = q1.pop_front();
            a = '{g1, r1, f1, e1};
            vectors++;
            if (a !== e) begin
              miscompares++;
              $display("FAIL sb_dut1 t=%0t: gpio/rise/fall/ev got %h/%h/%h/%b want %h/%h/%h/%b",
                       $time, a.gpio, a.rise, a.fall, a.ev, e.gpio, e.rise, e.fall, e.ev);
            end
          end
        end
      end
      begin : stimulus
        @(negedge clk);
        @(negedge clk);
        dchk("reset_state_dut0", 32'({g0, r0, f0, e0}), 32'd0);
        dchk("reset_state_dut1", 32'({g1, r1, f1, e1}), 32'd0);
        rst = 1'b1;

        // 00 -> 81: stable word follows at edge 6 with DEBOUNCE_CYCLES=4
        repeat (5) cycle(8'h81, 1'b0);
        dchk("lat_edge5_gpio", 32'(g0), 32'h00);
        cycle(8'h81, 1'b0);
        dchk("lat_edge6_gpio", 32'(g0), 32'h81);
        dchk("lat_edge6_rise", 32'(r0), 32'h81);
        cycle(8'h81, 1'b0);
        dchk("rise_one_cycle", 32'(r0), 32'h00);
        dchk("event_sticky", 32'(e0), 32'd1);

        // ack clears, then ack coincides with a debounced fall of bit 7
        cycle(8'h81, 1'b1);
        dchk("ack_clears", 32'(e0), 32'd0);
        repeat (5) cycle(8'h01, 1'b0);
        cycle(8'h01, 1'b1);
        dchk("ack_vs_fall_fall", 32'(f0), 32'h80);
        dchk("ack_vs_fall_event", 32'(e0), 32'd1);
        cycle(8'h01, 1'b0);

        // bounce on bit 0, then hold
        cycle(8'h00, 1'b0);
        repeat (6) cycle(8'h00, 1'b0);
        cycle(8'h01, 1'b0); cycle(8'h00, 1'b0); cycle(8'h01, 1'b0);
        cycle(8'h00, 1'b0); cycle(8'h01, 1'b0);
        repeat (10) cycle(8'h01, 1'b0);

        // glitch on bit 3 shorter than the debounce window
        repeat (3) cycle(8'h09, 1'b0);
        repeat (8) cycle(8'h01, 1'b0);
        dchk("glitch_gpio3", 32'(g0), 32'h01);

        // debounce-1 instance: 00 -> FF at edge 3, then FF -> 00
        do_reset();
        repeat (2) cycle(8'hFF, 1'b0);
        dchk("n1_edge2_gpio", 32'(g1), 32'h00);
        cycle(8'hFF, 1'b0);
        dchk("n1_edge3_gpio", 32'(g1), 32'hFF);
        repeat (3) cycle(8'h00, 1'b0);
        dchk("n1_fall", 32'(f1), 32'hFF);
        dchk("n1_gpio_low", 32'(g1), 32'h00);

        // reset mid-count with pins held high
        repeat (3) cycle(8'hF0, 1'b0);
        do_reset();
        repeat (5) cycle(8'hF0, 1'b0);
        dchk("post_rst_edge5", 32'(g0), 32'h00);
        cycle(8'hF0, 1'b0);
        dchk("post_rst_edge6", 32'(g0), 32'hF0);

        // randomized phase: sparse toggles, occasional ack, one reset
        rp = pins;
        for (int k = 0; k < 1200; k++) begin
          if (k == 600) do_reset();
          if ($urandom_range(7) == 0)
            rp = rp ^ W'($urandom & $urandom);
          cycle(rp, ($urandom_range(5) == 0));
        end
        repeat (8) cycle(rp, 1'b0);
      end
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
